// File: rtl/ALUparams.sv
// ALUparams: opcodes, NaN constant and issue FSM states shared by fpu_issue and fp_alu
package ALUparams;
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [15:0] FP_NAN = 16'h7E00;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  function automatic logic is_legal(input logic [2:0] o);
    return o inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV};
  endfunction
endpackage

// File: rtl/fpu_issue.sv
// fpu_issue: one-at-a-time half-precision op issuer with ALU wait timeout and held response
module fpu_issue
  import ALUparams::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [3:0]  req_tag,
  output logic        sop,
  output logic [2:0]  op,
  output logic [15:0] fpA,
  output logic [15:0] fpB,
  input  logic        alu_rdy,
  input  logic [15:0] alu_out,
  input  logic [4:0]  alu_flags,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic [15:0] rsp_data,
  output logic [4:0]  rsp_flags,
  output logic [3:0]  rsp_tag,
  output logic        rsp_timeout,
  output logic        rsp_illegal
);
  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [3:0]  tag_q, tag_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  flags_q, flags_d;
  logic        tmo_q, tmo_d, ill_q, ill_d;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    flags_d = flags_q;
    tmo_d   = tmo_q;
    ill_d   = ill_q;
    case (state_q)
      IDLE: if (req_vld) begin
        op_d    = req_op;
        a_d     = req_a;
        b_d     = req_b;
        tag_d   = req_tag;
        data_d  = FP_NAN;
        flags_d = '0;
        tmo_d   = 1'b0;
        ill_d   = !is_legal(req_op);
        state_d = is_legal(req_op) ? ISSUE : RESP;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (alu_rdy && cnt_q != 8'd0) begin
          data_d  = alu_out;
          flags_d = alu_flags;
          tmo_d   = 1'b0;
          ill_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          data_d  = FP_NAN;
          flags_d = '0;
          tmo_d   = 1'b1;
          ill_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP: state_d = rsp_rdy ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      data_q  <= FP_NAN;
      flags_q <= '0;
      tmo_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      tmo_q   <= tmo_d;
      ill_q   <= ill_d;
    end
  end
  assign req_rdy     = rst_n && state_q == IDLE;
  assign sop         = state_q == ISSUE;
  assign op          = op_q;
  assign fpA         = a_q;
  assign fpB         = b_q;
  assign rsp_vld     = state_q == RESP;
  assign rsp_data    = data_q;
  assign rsp_flags   = flags_q;
  assign rsp_tag     = tag_q;
  assign rsp_timeout = tmo_q;
  assign rsp_illegal = ill_q;
endmodule
